// File: rtl/add_seq32.sv
// Byte-serial add/subtract: one 8-bit slice reused LSB-first, done pulses NBYTES+1 edges after start.
// No backpressure: start is only taken in IDLE/DONE, and requests arriving during RUN are dropped.
module add_seq32 #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_q, b_q, res_q, res_nxt;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [7:0]      a_byte, b_byte, s_byte;
  logic            c_out;
  logic            last;
  logic            accept;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (idx == IW'(NBYTES - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // The only adder in the block: one 8-bit slice with carry in/out.
  assign a_byte = a_q[{idx, 3'b000} +: 8];
  assign b_byte = b_q[{idx, 3'b000} +: 8];
  assign {c_out, s_byte} = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry};

  always_comb begin
    res_nxt = res_q;
    res_nxt[{idx, 3'b000} +: 8] = s_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1; the +1 rides in on the initial carry.
      a_q   <= a;
      b_q   <= sub ? ~b : b;
      carry <= sub;
      idx   <= '0;
    end else if (state == RUN) begin
      res_q <= res_nxt;
      carry <= c_out;
      idx   <= idx + IW'(1);
      if (last) begin
        sum  <= res_nxt;
        cout <= c_out;
        ovf  <= (a_q[W-1] == b_q[W-1]) && (s_byte[7] != a_q[W-1]);
      end
    end
  end

endmodule

// File: tb/tb_add_seq32.sv
// Directed and random checks of add_seq32 with a result scoreboard queue.
module tb_add_seq32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, cout, ovf;
  logic [31:0] sum;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  res_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  add_seq32 #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    res_t        r;
    logic [31:0] be;
    logic [32:0] t;
    be     = s ? ~y : y;
    t      = {1'b0, x} + {1'b0, be} + {32'd0, s};
    r.sum  = t[31:0];
    r.cout = t[32];
    r.ovf  = (x[31] == be[31]) && (t[31] != x[31]);
    return r;
  endfunction

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                        input logic [31:0] es, input logic ec, input logic eo, input string tag);
    res_t        e;
    logic [31:0] held;
    int          nb;
    bit          seen;
    sb.push_back({es, ec, eo});
    held  = sum;
    start = 1'b1; a = ta; b = tb_; sub = ts;
    nb = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0; a = $urandom; b = $urandom; sub = 1'($urandom);
      if (done) seen = 1;
      else begin
        if (busy) nb++;
        check({tag, " sum held"}, sum, held);
      end
    end
    check({tag, " done seen"}, seen, 1);
    check({tag, " busy cycles"}, nb, 4);
    e = sb.pop_front();
    if (seen) begin
      check({tag, " sum"}, sum, e.sum);
      check({tag, " cout"}, cout, e.cout);
      check({tag, " ovf"}, ovf, e.ovf);
    end
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    res_t        r;
    logic [31:0] ra, rb, hs;
    logic        rs, hc, ho;

    // Reset state, then start on the very first edge after release.
    #12;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst sum", sum, 0);
    check("rst cout", cout, 0);
    check("rst ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "carry");
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "wrap");
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "posovf");
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub neg");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub ovf");

    for (int k = 0; k < 6; k++) begin
      ra = $urandom; rb = $urandom; rs = 1'($urandom);
      r  = model(ra, rb, rs);
      run_op(ra, rb, rs, r.sum, r.cout, r.ovf, "random");
    end

    // Outputs hold while idle with operands wiggling.
    hs = sum; hc = cout; ho = ovf;
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom);
      @(negedge clk);
      check("hold sum", sum, hs);
      check("hold cout", cout, hc);
      check("hold ovf", ovf, ho);
      check("hold busy", busy, 0);
      check("hold done", done, 0);
    end

    // start held high: accepted back-to-back from DONE, ignored during RUN.
    sb.push_back({32'h0000_0003, 1'b0, 1'b0});
    sb.push_back({32'h0000_0003, 1'b0, 1'b0});
    start = 1'b1; a = 32'd1; b = 32'd2; sub = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("hs done", done, (i == 4 || i == 9));
      check("hs busy", busy, (i < 4) || (i > 4 && i < 9));
      if (done) begin
        r = sb.pop_front();
        check("hs sum", sum, r.sum);
        check("hs cout", cout, r.cout);
        check("hs ovf", ovf, r.ovf);
      end
      if (i == 9) start = 1'b0;
    end
    check("hs queue empty", sb.size(), 0);

    // Asynchronous reset two cycles into RUN, away from any clock edge.
    start = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst sum", sum, 0);
    check("arst cout", cout, 0);
    check("arst ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post-rst done", done, 0);
      check("post-rst busy", busy, 0);
    end

    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, "recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
